dcache_assoc: RTL
=================

# dcache_assoc

Parametrised N-way set-associative data cache with write-back, write-allocate policy and an integrated miss/eviction state machine. It sits between the MEM stage and the shared memory port. It supersedes the externally sequenced 2-way data cache: refill and writeback are driven internally, and way count, set count and line length are parameters. Victim selection is true LRU over any power-of-two way count.

## Interface
- WAYS, 2, associativity; 1, 2 or 4
- SET_BITS, 6, log2 of set count
- WORD_BITS, 3, log2 of 16-bit words per line; tag width is 15-SET_BITS-WORD_BITS
- clk  in  1  clock, all state updates on posedge
- rst_n  in  1  reset, asynchronous, active-low
- cpu_req  in  1  access valid; held stable with cpu_we/addr/wdata while mem_stall=1
- cpu_we  in  1  1 = store, 0 = load
- cpu_addr  in  16  byte address; bit 0 ignored; [WORD_BITS:1] word offset, next SET_BITS index, rest tag
- cpu_wdata  in  16  store data
- cpu_rdata  out  16  load data, valid when cpu_req & ~cpu_we & ~mem_stall; 0 otherwise
- mem_stall  out  1  pipeline freeze
- mem_req  out  1  memory word request, held until mem_ack
- mem_we  out  1  1 = writeback word, 0 = fill word
- mem_addr  out  16  word-aligned byte address of the current transfer
- mem_wdata  out  16  writeback data
- mem_rdata  in  16  fill data, sampled when mem_ack=1
- mem_ack  in  1  word transfer completes this cycle

## Operation
- Per line state: valid, dirty, tag, age (log2(WAYS) bits; absent when WAYS=1), data.
- Lookup is combinational. hit_w = valid_w & (tag_w == addr tag), and at most one way hits. hit = OR of hit_w.
- FSM states: IDLE, WB, FILL, DONE.
- IDLE:
  - cpu_req & hit & load: cpu_rdata comes from the hit way; the age update happens at posedge.
  - cpu_req & hit & store: the addressed word is written and dirty is set at posedge; ages update.
  - cpu_req & ~hit: the victim is latched (first invalid way, lowest index first; else the way with age WAYS-1), word counter is cleared, and FSM goes to WB if the victim is valid & dirty, else to FILL.
- WB:
  - mem_req=1, mem_we=1, mem_addr = {victim tag, index, counter, 0}, mem_wdata = victim word[counter].
  - On mem_ack the counter increments. On the last word the counter wraps to 0 and FSM goes to FILL.
- FILL:
  - mem_req=1, mem_we=0, mem_addr = {req tag, index, counter, 0}.
  - On mem_ack, mem_rdata is written into victim word[counter] and the counter increments.
  - On the last word: tag is written, valid=1, dirty=0, and FSM goes to DONE.
- DONE: one cycle with mem_req=0, then IDLE. The held request re-looks-up in IDLE and hits; a store is then applied as a store hit.
- LRU update on every hit access and at fill completion:
  - accessed way age becomes 0;
  - every way with age < old accessed age increments;
  - the others are unchanged.
  - Ages within a set always stay a permutation of 0..WAYS-1.
- mem_stall = (state != IDLE) | (cpu_req & ~hit).
- cpu_req dropping during WB/FILL does not abort; the line transfer completes.

## Timing
- Reset values:
  - FSM IDLE, all valid=0, dirty=0, ages of way w = w, counter 0.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rdata=0.
  - mem_stall=0 while cpu_req=0.
- rst_n assertion mid-WB/FILL: FSM returns to IDLE immediately (asynchronous), mem_req drops in the same instant, and all lines are invalid.
- Hit: zero-cycle stall; load data is valid in the same cycle.
- Clean miss with fixed mem_ack latency L per word: stall lasts 2^WORD_BITS*(L+1)+2 cycles. The +2 covers the IDLE detect cycle and DONE.
- Dirty miss: a further 2^WORD_BITS*(L+1) cycles of writeback.
- mem_ack with mem_req=0 is ignored. mem_ack in the same cycle as the request is legal (L=0).

## Test plan
- Cold read, defaults: addr 0x1234 with memory word k = k+0x100 → stall 10 cycles at L=0; then fill addresses 0x1230..0x123E and cpu_rdata=0x0102.
- Store hit then load: store 0x0009 to 0x1236, then load 0x1236 → 0x0009, no stall, no memory traffic.
- LRU, WAYS=2:
  - fill tags from 0x1234 and 0x1A34, touch 0x1234, then access 0x2234;
  - required: the 0x1A34 way is evicted; a following read of 0x1234 hits and a read of 0x1A34 misses.
- Dirty eviction: after the store above, force eviction of that line → 8 writes to 0x1230..0x123E, word 3 = 0x0009, before any fill read.
- WAYS=4, SET_BITS=4, WORD_BITS=2: five distinct tags in one set, accessed in order → the first is evicted; ages remain a permutation.
- rst_n pulsed mid-FILL at word 3 → mem_req=0 immediately; the next access to the same address misses and refills from word 0.

Source files
------------

// File: rtl/dcache_assoc.sv
// N-way set-associative write-back/write-allocate data cache with true-LRU
// replacement and an internal miss sequencer (writeback, then refill).
module dcache_assoc #(
  parameter int WAYS      = 2,
  parameter int SET_BITS  = 6,
  parameter int WORD_BITS = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        mem_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack
);

  localparam int SETS     = 1 << SET_BITS;
  localparam int WORDS    = 1 << WORD_BITS;
  localparam int TAG_BITS = 15 - SET_BITS - WORD_BITS;
  localparam int AW       = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam logic [AW-1:0] AGE_MAX = AW'(WAYS - 1);

  typedef enum logic [1:0] {IDLE, WB, FILL, DONE} state_t;
  state_t state_q, state_d;

  logic                valid_q [SETS][WAYS];
  logic                dirty_q [SETS][WAYS];
  logic [TAG_BITS-1:0] tag_q   [SETS][WAYS];
  logic [AW-1:0]       age_q   [SETS][WAYS];
  logic [15:0]         data_q  [SETS][WAYS][WORDS];

  logic [WORD_BITS-1:0] a_off, cnt_q;
  logic [SET_BITS-1:0]  a_idx, idx_q, lru_idx;
  logic [TAG_BITS-1:0]  a_tag, rtag_q;
  logic [AW-1:0]        hit_way, vic, vic_q, lru_way, old_age;
  logic                 hit, found, last, lru_en, unused_addr_bit;

  assign a_off = cpu_addr[WORD_BITS:1];
  assign a_idx = cpu_addr[WORD_BITS+SET_BITS:WORD_BITS+1];
  assign a_tag = cpu_addr[15:WORD_BITS+SET_BITS+1];
  assign unused_addr_bit = cpu_addr[0];
  assign last  = (cnt_q == '1);

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[a_idx][w] && (tag_q[a_idx][w] == a_tag)) begin
        hit     = 1'b1;
        hit_way = AW'(w);
      end
    end
  end

  // Victim: lowest-index invalid way, otherwise the least recently used one.
  always_comb begin
    found = 1'b0;
    vic   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!found && !valid_q[a_idx][w]) begin
        vic   = AW'(w);
        found = 1'b1;
      end
    end
    if (!found) begin
      for (int w = 0; w < WAYS; w++) begin
        if (age_q[a_idx][w] == AGE_MAX) vic = AW'(w);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (cpu_req && !hit)
              state_d = (valid_q[a_idx][vic] && dirty_q[a_idx][vic]) ? WB : FILL;
      WB:   if (mem_ack && last) state_d = FILL;
      FILL: if (mem_ack && last) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      WB: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {tag_q[idx_q][vic_q], idx_q, cnt_q, 1'b0};
        mem_wdata = data_q[idx_q][vic_q][cnt_q];
      end
      FILL: begin
        mem_req  = 1'b1;
        mem_addr = {rtag_q, idx_q, cnt_q, 1'b0};
      end
      default: ;
    endcase
  end

  assign mem_stall = (state_q != IDLE) | (cpu_req & ~hit);
  assign cpu_rdata = (cpu_req & ~cpu_we & ~mem_stall) ? data_q[a_idx][hit_way][a_off] : '0;

  // Ages are touched by a hit in IDLE or by the line that just finished filling.
  assign lru_en  = ((state_q == IDLE) && cpu_req && hit) ||
                   ((state_q == FILL) && mem_ack && last);
  assign lru_way = (state_q == FILL) ? vic_q : hit_way;
  assign lru_idx = (state_q == FILL) ? idx_q : a_idx;
  assign old_age = age_q[lru_idx][lru_way];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          dirty_q[s][w] <= 1'b0;
          tag_q[s][w]   <= '0;
          age_q[s][w]   <= AW'(w);
        end
      end
      cnt_q  <= '0;
      vic_q  <= '0;
      idx_q  <= '0;
      rtag_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (cpu_req) begin
          if (hit) begin
            if (cpu_we) dirty_q[a_idx][hit_way] <= 1'b1;
          end else begin
            vic_q  <= vic;
            idx_q  <= a_idx;
            rtag_q <= a_tag;
            cnt_q  <= '0;
          end
        end
        WB: if (mem_ack) cnt_q <= cnt_q + 1'b1;
        FILL: if (mem_ack) begin
          cnt_q <= cnt_q + 1'b1;
          if (last) begin
            tag_q[idx_q][vic_q]   <= rtag_q;
            valid_q[idx_q][vic_q] <= 1'b1;
            dirty_q[idx_q][vic_q] <= 1'b0;
          end
        end
        default: ;
      endcase
      if (lru_en) begin
        for (int w = 0; w < WAYS; w++) begin
          if (AW'(w) == lru_way)              age_q[lru_idx][w] <= '0;
          else if (age_q[lru_idx][w] < old_age) age_q[lru_idx][w] <= age_q[lru_idx][w] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if ((state_q == IDLE) && cpu_req && hit && cpu_we)
      data_q[a_idx][hit_way][a_off] <= cpu_wdata;
    if ((state_q == FILL) && mem_ack)
      data_q[idx_q][vic_q][cnt_q] <= mem_rdata;
  end

endmodule
